// File: rtl/flash_ctrl.sv
// flash_ctrl: timed x8 NOR flash byte read/write sequencer.
// One request runs SETUP -> PULSE -> HOLD -> DONE with registered, glitch-free strobes.
module flash_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] NF_A,
    inout  wire  [7:0] NF_D,
    output logic       NF_CE,
    output logic       NF_OE,
    output logic       NF_WE,
    output logic       NF_BYTE,
    output logic       NF_RP,
    output logic       NF_WP
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic       wr_op;
    logic       drive;
    logic [7:0] wd;
    assign NF_D    = drive ? wd : 8'bz;
    assign NF_BYTE = 1'b0;
    assign NF_RP   = 1'b1;
    assign NF_WP   = 1'b1;
    // cnt holds remaining cycles minus one for the current timed state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 4'd0;
            wr_op <= 1'b0;
            drive <= 1'b0;
            wd    <= 8'd0;
            rdata <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            NF_A  <= 8'd0;
            NF_CE <= 1'b1;
            NF_OE <= 1'b1;
            NF_WE <= 1'b1;
        end else begin
            case (state)
                IDLE: if (wr_req || rd_req) begin
                    state <= SETUP;
                    cnt   <= 4'(T_SETUP - 1);
                    wr_op <= wr_req;
                    drive <= wr_req;
                    wd    <= wdata;
                    NF_A  <= addr;
                    NF_CE <= 1'b0;
                    busy  <= 1'b1;
                end
                SETUP: if (cnt == 4'd0) begin
                    state <= PULSE;
                    cnt   <= 4'(T_PULSE - 1);
                    NF_OE <= wr_op;
                    NF_WE <= !wr_op;
                end else cnt <= cnt - 4'd1;
                PULSE: if (cnt == 4'd0) begin
                    state <= HOLD;
                    cnt   <= 4'(T_HOLD - 1);
                    NF_OE <= 1'b1;
                    NF_WE <= 1'b1;
                    if (!wr_op) rdata <= NF_D;
                end else cnt <= cnt - 4'd1;
                HOLD: if (cnt == 4'd0) begin
                    state <= DONE;
                    NF_CE <= 1'b1;
                    drive <= 1'b0;
                    done  <= 1'b1;
                end else cnt <= cnt - 4'd1;
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: directed bench for flash_ctrl with a simple byte-wide flash model.
// u0 uses default timing, u1 uses the minimum 1/1/1 timing.
module tb_flash_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_req = 1'b0, wr_req = 1'b0, rd_req1 = 1'b0, wr_req1 = 1'b0;
    logic [7:0] addr = 8'd0, wdata = 8'd0, addr1 = 8'd0, wdata1 = 8'd0;
    logic [7:0] rdata, rdata1, nf_a, nf_a1;
    logic       busy, done, nf_ce, nf_oe, nf_we, nf_byte, nf_rp, nf_wp;
    logic       busy1, done1, nf_ce1, nf_oe1, nf_we1, nf_byte1, nf_rp1, nf_wp1;
    wire  [7:0] nf_d, nf_d1;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int checks = 0, passes = 0;
    int ce_n, we_n, oe_n, we_first, we_last, oe_first, busy_n, done_n, done_at, d_drv, d_val;
    logic [7:0] rd_at_done;

    always #5 clk = ~clk;

    flash_ctrl u0 (
        .CLK(clk), .RST(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .NF_A(nf_a), .NF_D(nf_d), .NF_CE(nf_ce),
        .NF_OE(nf_oe), .NF_WE(nf_we), .NF_BYTE(nf_byte), .NF_RP(nf_rp), .NF_WP(nf_wp)
    );
    flash_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) u1 (
        .CLK(clk), .RST(rst), .rd_req(rd_req1), .wr_req(wr_req1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .busy(busy1), .done(done1), .NF_A(nf_a1), .NF_D(nf_d1), .NF_CE(nf_ce1),
        .NF_OE(nf_oe1), .NF_WE(nf_we1), .NF_BYTE(nf_byte1), .NF_RP(nf_rp1), .NF_WP(nf_wp1)
    );

    // Undriven bus floats to 8'hFF so a released bus is observable in any simulator
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (nf_d[i]);
        pullup (nf_d1[i]);
    end
    assign nf_d  = (!nf_oe && !nf_ce) ? mem0[nf_a] : 8'bz;
    assign nf_d1 = (!nf_oe1 && !nf_ce1) ? mem1[nf_a1] : 8'bz;
    always @(posedge nf_we) if (!nf_ce) mem0[nf_a] = nf_d;
    always @(posedge nf_we1) if (!nf_ce1) mem1[nf_a1] = nf_d1;

    task automatic run_op(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d, input int inj);
        @(posedge clk); #1;
        wr_req = w; rd_req = r; addr = a; wdata = d;
        ce_n = 0; we_n = 0; oe_n = 0; we_first = 0; we_last = 0; oe_first = 0;
        busy_n = 0; done_n = 0; done_at = 0; d_drv = 0; d_val = 0; rd_at_done = 8'd0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            rd_req = 1'b0; wr_req = (k == inj); addr = ~a; wdata = ~d;
            if (!nf_ce) ce_n++;
            if (!nf_we) begin we_n++; if (we_first == 0) we_first = k; we_last = k; end
            if (!nf_oe) begin oe_n++; if (oe_first == 0) oe_first = k; end
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = k; rd_at_done = rdata; end
            if (nf_d !== 8'hFF) d_drv++;
            if (nf_d === d) d_val++;
        end
        wr_req = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passes++;
        checks++; if ({nf_ce, nf_oe, nf_we} !== 3'b111) $display("FAIL rst_strobes got %b want 111", {nf_ce, nf_oe, nf_we}); else passes++;
        checks++; if (nf_a !== 8'h00) $display("FAIL rst_nf_a got %h want 00", nf_a); else passes++;
        checks++; if (rdata !== 8'h00) $display("FAIL rst_rdata got %h want 00", rdata); else passes++;
        checks++; if (nf_d !== 8'hFF) $display("FAIL rst_nf_d got %h want released (FF)", nf_d); else passes++;
        checks++; if ({nf_byte, nf_rp, nf_wp} !== 3'b011) $display("FAIL rst_const got %b want 011", {nf_byte, nf_rp, nf_wp}); else passes++;
        checks++; if ({busy1, nf_ce1} !== 2'b01) $display("FAIL rst_u1 got %b want 01", {busy1, nf_ce1}); else passes++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_write;
        run_op(1'b1, 1'b0, 8'h15, 8'h5A, 0);
        checks++; if (ce_n !== 8) $display("FAIL wr_ce_low got %0d want 8", ce_n); else passes++;
        checks++; if (we_n !== 4 || we_first !== 3 || we_last !== 6) $display("FAIL wr_we_window got n=%0d %0d..%0d want n=4 3..6", we_n, we_first, we_last); else passes++;
        checks++; if (oe_n !== 0) $display("FAIL wr_oe_low got %0d want 0", oe_n); else passes++;
        checks++; if (d_val !== 8 || d_drv !== 8) $display("FAIL wr_nf_d got val=%0d drv=%0d want 8/8", d_val, d_drv); else passes++;
        checks++; if (done_n !== 1 || done_at !== 9) $display("FAIL wr_done got n=%0d at %0d want 1 at 9", done_n, done_at); else passes++;
        checks++; if (busy_n !== 9) $display("FAIL wr_busy got %0d want 9", busy_n); else passes++;
        checks++; if (mem0[8'h15] !== 8'h5A) $display("FAIL wr_mem got %h want 5A", mem0[8'h15]); else passes++;
        checks++; if (nf_a !== 8'h15) $display("FAIL wr_addr_hold got %h want 15", nf_a); else passes++;
        checks++; if (rdata !== 8'h00) $display("FAIL wr_rdata got %h want 00", rdata); else passes++;
    endtask

    task automatic test_read;
        run_op(1'b0, 1'b1, 8'h15, 8'h5A, 0);
        checks++; if (oe_n !== 4 || oe_first !== 3) $display("FAIL rd_oe got n=%0d first=%0d want 4/3", oe_n, oe_first); else passes++;
        checks++; if (we_n !== 0) $display("FAIL rd_we got %0d want 0", we_n); else passes++;
        checks++; if (d_drv !== 4 || d_val !== 4) $display("FAIL rd_bus got drv=%0d val=%0d want 4/4", d_drv, d_val); else passes++;
        checks++; if (rd_at_done !== 8'h5A || done_n !== 1) $display("FAIL rd_rdata got %h n=%0d want 5A n=1", rd_at_done, done_n); else passes++;
        checks++; if (busy_n !== 9 || ce_n !== 8) $display("FAIL rd_busy_ce got %0d/%0d want 9/8", busy_n, ce_n); else passes++;
    endtask

    task automatic test_both_req;
        run_op(1'b1, 1'b1, 8'h03, 8'h7E, 0);
        checks++; if (we_n !== 4 || oe_n !== 0) $display("FAIL both_strobes got we=%0d oe=%0d want 4/0", we_n, oe_n); else passes++;
        checks++; if (mem0[8'h03] !== 8'h7E) $display("FAIL both_mem got %h want 7E", mem0[8'h03]); else passes++;
        checks++; if (rdata !== 8'h5A) $display("FAIL both_rdata got %h want 5A", rdata); else passes++;
        checks++; if (done_n !== 1) $display("FAIL both_done got %0d want 1", done_n); else passes++;
    endtask

    task automatic test_busy_ignore;
        run_op(1'b0, 1'b1, 8'h03, 8'h7E, 4);
        checks++; if (done_n !== 1) $display("FAIL ign_done got %0d want 1", done_n); else passes++;
        checks++; if (we_n !== 0 || oe_n !== 4) $display("FAIL ign_strobes got we=%0d oe=%0d want 0/4", we_n, oe_n); else passes++;
        checks++; if (mem0[8'hFC] !== 8'h00) $display("FAIL ign_mem got %h want 00", mem0[8'hFC]); else passes++;
        checks++; if (rdata !== 8'h7E) $display("FAIL ign_rdata got %h want 7E", rdata); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL ign_idle got %b want 0", busy); else passes++;
    endtask

    task automatic test_reset_mid_write;
        int dn;
        @(posedge clk); #1;
        wr_req = 1'b1; addr = 8'h40; wdata = 8'hC3;
        @(posedge clk); #1;
        wr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (nf_we !== 1'b0) $display("FAIL mid_we_pre got %b want 0", nf_we); else passes++;
        rst = 1'b1;
        #1;
        checks++; if ({nf_ce, nf_we} !== 2'b11) $display("FAIL mid_strobes got %b want 11", {nf_ce, nf_we}); else passes++;
        checks++; if (nf_d !== 8'hFF) $display("FAIL mid_nf_d got %h want released (FF)", nf_d); else passes++;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL mid_busy_done got %b want 00", {busy, done}); else passes++;
        checks++; if (rdata !== 8'h00) $display("FAIL mid_rdata got %h want 00", rdata); else passes++;
        @(posedge clk); #1 rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++; if (dn !== 0) $display("FAIL mid_no_done got %0d want 0", dn); else passes++;
        run_op(1'b0, 1'b1, 8'h15, 8'h5A, 0);
        checks++; if (done_n !== 1 || rd_at_done !== 8'h5A) $display("FAIL mid_next_read got n=%0d %h want 1 5A", done_n, rd_at_done); else passes++;
        checks++; if (busy_n !== 9) $display("FAIL mid_next_busy got %0d want 9", busy_n); else passes++;
    endtask

    task automatic set_fast(input int i);
        logic       fw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] fa [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [7:0] fd [4] = '{8'hA5, 8'h00, 8'h3C, 8'h00};
        wr_req1 = (i < 4) ? fw[i] : 1'b0;
        rd_req1 = (i < 4) ? !fw[i] : 1'b0;
        addr1   = (i < 4) ? fa[i] : 8'h00;
        wdata1  = (i < 4) ? fd[i] : 8'h00;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_rd [4] = '{8'h00, 8'hA5, 8'h00, 8'h3C};
        int idx = 0, run = 0, gap = 0, nruns = 0;
        @(posedge clk); #1;
        set_fast(0);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (busy1) begin
                if (run == 0 && nruns > 0) begin
                    checks++; if (gap !== 1) $display("FAIL b2b_gap%0d got %0d want 1", nruns, gap); else passes++;
                end
                run++; gap = 0;
            end else begin
                if (run > 0) begin
                    checks++; if (run !== 4) $display("FAIL b2b_busy%0d got %0d want 4", nruns, run); else passes++;
                    nruns++;
                end
                run = 0; gap++;
            end
            if (done1 && idx < 4) begin
                if (idx % 2 == 1) begin
                    checks++; if (rdata1 !== exp_rd[idx]) $display("FAIL b2b_rdata%0d got %h want %h", idx, rdata1, exp_rd[idx]); else passes++;
                end
                idx++;
                set_fast(idx);
            end
            if (idx == 4 && !busy1) break;
        end
        checks++; if (idx !== 4 || nruns !== 4) $display("FAIL b2b_ops got %0d/%0d want 4/4", idx, nruns); else passes++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        test_reset;
        test_write;
        test_read;
        test_both_req;
        test_busy_ignore;
        test_reset_mid_write;
        test_back_to_back;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
